operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter: TIMEOUT, default 15; max cycles in ISSUE waiting for rf_busy, range 1..255.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  upstream request present.
REQ-005 req_ready  output  1  request accepted when req_valid & req_ready at a rising edge.
REQ-006 req_write  input  1  1 = write request, 0 = read request.
REQ-007 req_rd / req_rs1 / req_rs2  input  4 each  write address / read address A / read address B.
REQ-008 req_wdata  input  32  write data.
REQ-009 rsp_valid  output  1  read operands valid.
REQ-010 rsp_ready  input  1  downstream consumes on rsp_valid & rsp_ready.
REQ-011 rsp_a / rsp_b  output  32 each  captured operands A/B.
REQ-012 rf_available  output  1  operation offered to register file.
REQ-013 rf_write_en  output  1  register-file write enable.
REQ-014 rf_write_addr  output  4  register-file write address.
REQ-015 rf_write_data  output  32  register-file write data.
REQ-016 rf_read_addr_a / rf_read_addr_b  output  4 each  register-file read addresses.
REQ-017 rf_read_data_a / rf_read_data_b  input  32 each  register-file read data.
REQ-018 rf_busy  input  1  register-file operation busy.
REQ-019 err  output  1  sticky timeout flag.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT, RELEASE, RESP.
REQ-021 req_ready = 1 only in IDLE.
REQ-022 IDLE: on accept, latch req_write/addresses/wdata into holding registers, go ISSUE.
REQ-023 rf_write_en/rf_write_addr/rf_write_data/rf_read_addr_a/rf_read_addr_b driven only from holding registers; stable from ISSUE entry until the next accept.
REQ-024 rf_available = 1 in ISSUE and WAIT only; 0 in IDLE, RELEASE, RESP.
REQ-025 ISSUE: rf_busy sampled 1 -> WAIT; counter increments each ISSUE cycle and clears on ISSUE entry.
REQ-026 ISSUE timeout: counter reaches TIMEOUT with rf_busy still 0 -> set err, go RELEASE, request dropped (no response, no retry).
REQ-027 WAIT: rf_busy sampled 0 -> go RELEASE; for a read, capture rf_read_data_a/b into rsp_a/rsp_b on that same edge.
REQ-028 WAIT has no timeout; rf_available held 1 throughout, as required by the register file.
REQ-029 RELEASE lasts exactly one cycle with rf_available = 0, letting the register file return idle; then write -> IDLE, read -> RESP.
REQ-030 RESP: rsp_valid = 1; rsp_a/rsp_b stable until rsp_ready sampled 1, then -> IDLE.
REQ-031 rsp_valid = 0 in all states other than RESP.
REQ-032 Minimum request spacing: write 4 cycles, read 5 cycles (rsp_ready tied 1), with a 1-cycle rf_busy response.
REQ-033 Address 0 needs no special handling; zeroing is the register file's responsibility.
REQ-034 req_valid while not IDLE: ignored, not accepted.
REQ-035 err remains 1 until reset; later requests still serviced normally.

Reset
REQ-036 reset_n low asynchronously forces: state IDLE, counter 0, err 0, rf_available 0, rsp_valid 0, rsp_a/rsp_b 0, holding registers 0.
REQ-037 Reset mid-operation (any state) abandons the operation with no response; the register file is reset by the same reset_n.
REQ-038 req_ready = 1 on the first rising edge after reset_n deasserts.

Verification
REQ-039 Write r5 = 0xDEADBEEF, rf_busy high for 1 cycle -> rf_available high exactly 2 cycles, rf_write_addr = 5; read r5 -> rsp_a = 0xDEADBEEF.
REQ-040 Read rs1 = 0, rs2 = 3 (r3 = 0x12345678) -> rsp_a = 0, rsp_b = 0x12345678, rsp_valid held 1 with rsp_ready = 0 for 4 cycles, then 1-cycle accept.
REQ-041 rf_busy tied 0, TIMEOUT = 15 -> err rises on the 15th ISSUE cycle, rf_available 0 next cycle, no rsp_valid, req_ready back to 1.
REQ-042 reset_n low during WAIT -> rf_available and rsp_valid 0 immediately (asynchronous), state IDLE, err 0.
REQ-043 Back-to-back write r7 = 1 then read r7 with req_valid held 1 -> exactly one RELEASE cycle between operations; rsp_a = 1.
REQ-044 Assertions: rf_* outputs stable while rf_available = 1; rf_available never deasserts while rf_busy = 1.

Source files
------------

// File: rtl/operand_fetch_if.sv
// Request/response handshake plus register-file port bundle for operand_fetch.
// The fetch unit takes the slave view; the requester/register-file side takes master.
interface operand_fetch_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [3:0]  req_rd;
   logic [3:0]  req_rs1;
   logic [3:0]  req_rs2;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_a;
   logic [31:0] rsp_b;
   logic        rf_available;
   logic        rf_write_en;
   logic [3:0]  rf_write_addr;
   logic [31:0] rf_write_data;
   logic [3:0]  rf_read_addr_a;
   logic [3:0]  rf_read_addr_b;
   logic [31:0] rf_read_data_a;
   logic [31:0] rf_read_data_b;
   logic        rf_busy;
   logic        err;

   modport slave (
      input  req_valid, req_write, req_rd, req_rs1, req_rs2, req_wdata,
      input  rsp_ready, rf_read_data_a, rf_read_data_b, rf_busy,
      output req_ready, rsp_valid, rsp_a, rsp_b, rf_available,
      output rf_write_en, rf_write_addr, rf_write_data,
      output rf_read_addr_a, rf_read_addr_b, err
   );

   modport master (
      output req_valid, req_write, req_rd, req_rs1, req_rs2, req_wdata,
      output rsp_ready, rf_read_data_a, rf_read_data_b, rf_busy,
      input  req_ready, rsp_valid, rsp_a, rsp_b, rf_available,
      input  rf_write_en, rf_write_addr, rf_write_data,
      input  rf_read_addr_a, rf_read_addr_b, err
   );
endinterface

// File: rtl/operand_fetch.sv
// Single-outstanding operand fetch: offers one read or write to the register file,
// waits out its busy handshake, then returns captured read operands downstream.
module operand_fetch #(
   parameter int TIMEOUT = 15
) (
   input logic            clk,
   input logic            reset_n,
   operand_fetch_if.slave bus
);

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RELEASE,
      S_RESP
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d, cnt_inc;
   logic        err_q, err_d;
   logic        drop_q, drop_d;
   logic        wr_q, wr_d;
   logic [3:0]  rd_q, rd_d;
   logic [3:0]  rs1_q, rs1_d;
   logic [3:0]  rs2_q, rs2_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rsp_a_q, rsp_a_d;
   logic [31:0] rsp_b_q, rsp_b_d;

   assign cnt_inc = cnt_q + 8'd1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      drop_d  = drop_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      wdata_d = wdata_q;
      rsp_a_d = rsp_a_q;
      rsp_b_d = rsp_b_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               wr_d    = bus.req_write;
               rd_d    = bus.req_rd;
               rs1_d   = bus.req_rs1;
               rs2_d   = bus.req_rs2;
               wdata_d = bus.req_wdata;
               cnt_d   = '0;
               drop_d  = 1'b0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (bus.rf_busy) begin
               state_d = S_WAIT;
            end else begin
               cnt_d = cnt_inc;
               // Register file never answered: abandon the request, no retry.
               if (cnt_inc == TIMEOUT_C) begin
                  err_d   = 1'b1;
                  drop_d  = 1'b1;
                  state_d = S_RELEASE;
               end
            end
         end
         S_WAIT: begin
            if (!bus.rf_busy) begin
               if (!wr_q) begin
                  rsp_a_d = bus.rf_read_data_a;
                  rsp_b_d = bus.rf_read_data_b;
               end
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            state_d = (wr_q || drop_q) ? S_IDLE : S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         drop_q  <= 1'b0;
         wr_q    <= 1'b0;
         rd_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         wdata_q <= '0;
         rsp_a_q <= '0;
         rsp_b_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         drop_q  <= drop_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         wdata_q <= wdata_d;
         rsp_a_q <= rsp_a_d;
         rsp_b_q <= rsp_b_d;
      end
   end

   // Register-file side is decoded from state and holding registers only.
   assign bus.req_ready      = (state_q == S_IDLE);
   assign bus.rf_available   = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign bus.rf_write_en    = wr_q;
   assign bus.rf_write_addr  = rd_q;
   assign bus.rf_write_data  = wdata_q;
   assign bus.rf_read_addr_a = rs1_q;
   assign bus.rf_read_addr_b = rs2_q;
   assign bus.rsp_valid      = (state_q == S_RESP);
   assign bus.rsp_a          = rsp_a_q;
   assign bus.rsp_b          = rsp_b_q;
   assign bus.err            = err_q;

   a_rf_stable: assert property (@(posedge clk) disable iff (!reset_n)
      bus.rf_available |=> (!bus.rf_available ||
         $stable({bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data,
                  bus.rf_read_addr_a, bus.rf_read_addr_b})));

   a_hold_while_busy: assert property (@(posedge clk) disable iff (!reset_n)
      (bus.rf_available && bus.rf_busy) |=> bus.rf_available);

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized scoreboard bench for operand_fetch with a latency-programmable
// register-file model and an abstract register-array reference.
module tb_operand_fetch;
   localparam int TIMEOUT = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   operand_fetch_if bif ();
   operand_fetch #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset_n(rst_n), .bus(bif));

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          last_acc = 0;
   int          rst_cnt = 0;
   int          cfg_lat = 0;
   int          cfg_dur = 1;
   int          rdy_mode = 0;
   int          wc = 0;
   int          phase;
   logic [31:0] rf_mem [16];
   logic [31:0] ref_regs [16];
   logic [63:0] exp_q [$];
   bit          exp_err = 1'b0;
   logic [44:0] rfvec;

   // monitor-private state
   int          m_seen = 0;
   int          m_vcyc = 0;
   bit          m_phold = 1'b0;
   bit          m_pav = 1'b0;
   bit          m_pbusy = 1'b0;
   logic [44:0] m_prf;
   logic [31:0] m_pa, m_pb;
   logic [63:0] m_e;

   assign rfvec = {bif.rf_write_en, bif.rf_write_addr, bif.rf_write_data,
                   bif.rf_read_addr_a, bif.rf_read_addr_b};

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge rst_n) rst_cnt <= rst_cnt + 1;

   // Register file: busy for cfg_dur cycles starting cfg_lat cycles into the offer.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= 0;
         for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
      end else begin
         phase <= bif.rf_available ? phase + 1 : 0;
         if (bif.rf_available && bif.rf_busy && bif.rf_write_en &&
             phase == cfg_lat + cfg_dur - 1)
            rf_mem[bif.rf_write_addr] <= bif.rf_write_data;
      end
   end
   assign bif.rf_busy = bif.rf_available && (phase >= cfg_lat) && (phase < cfg_lat + cfg_dur);
   assign bif.rf_read_data_a = (bif.rf_read_addr_a == 4'd0) ? 32'd0 : rf_mem[bif.rf_read_addr_a];
   assign bif.rf_read_data_b = (bif.rf_read_addr_b == 4'd0) ? 32'd0 : rf_mem[bif.rf_read_addr_b];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Downstream ready: random, or held low for four RESP cycles then accepted.
   initial begin
      bif.rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0) begin
            bif.rsp_ready = 1'($urandom_range(0, 1));
         end else if (bif.rsp_valid) begin
            wc++;
            bif.rsp_ready = (wc > 4);
         end else begin
            wc = 0;
            bif.rsp_ready = 1'b0;
         end
      end
   end

   // Monitor: pops expected operands on every rsp handshake, checks hold rules.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_cnt != m_seen || !rst_n) begin
            m_seen = rst_cnt;
            m_phold = 1'b0;
            m_pav = 1'b0;
            m_pbusy = 1'b0;
            m_vcyc = 0;
         end else begin
            if (m_pav && bif.rf_available) chk("rf_stable", 64'(rfvec), 64'(m_prf));
            if (m_pav && m_pbusy) chk("avail_held_busy", 64'(bif.rf_available), 64'd1);
            m_pav = bif.rf_available;
            m_pbusy = bif.rf_busy;
            m_prf = rfvec;
            if (bif.rsp_valid) begin
               m_vcyc++;
               if (m_phold) chk("rsp_hold", {bif.rsp_a, bif.rsp_b}, {m_pa, m_pb});
               if (bif.rsp_ready) begin
                  if (exp_q.size() == 0) begin
                     vectors++;
                     miscompares++;
                     $display("FAIL rsp_unexpected: got rsp a=%h b=%h, required no response",
                              bif.rsp_a, bif.rsp_b);
                  end else begin
                     m_e = exp_q.pop_front();
                     chk("rsp_a", 64'(bif.rsp_a), 64'(m_e[63:32]));
                     chk("rsp_b", 64'(bif.rsp_b), 64'(m_e[31:0]));
                     if (rdy_mode == 1) chk("rsp_valid_cycles", 64'(m_vcyc), 64'd5);
                  end
                  m_vcyc = 0;
                  m_phold = 1'b0;
               end else begin
                  m_phold = 1'b1;
               end
               m_pa = bif.rsp_a;
               m_pb = bif.rsp_b;
            end else begin
               m_vcyc = 0;
               m_phold = 1'b0;
            end
         end
      end
   end

   // One request end to end; called and returns on a falling edge.
   task automatic do_req(input bit wr, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic [31:0] wd, input int lat,
                         input int dur, input bit hold, input int gap);
      int   n;
      int   av;
      int   exp_av;
      bit   to;
      bit   fell;
      logic err_fall;
      n = 0;
      while (!bif.req_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 64'(bif.req_ready), 64'd1);
      if (!bif.req_ready) return;
      if (gap >= 0) chk("accept_gap", 64'(cyc - last_acc), 64'(gap));
      last_acc = cyc;
      cfg_lat = lat;
      cfg_dur = dur;
      bif.req_valid = 1'b1;
      bif.req_write = wr;
      bif.req_rd = rd;
      bif.req_rs1 = rs1;
      bif.req_rs2 = rs2;
      bif.req_wdata = wd;
      to = (lat >= TIMEOUT);
      exp_av = to ? TIMEOUT : lat + dur + 1;
      if (to) exp_err = 1'b1;
      else if (wr) begin
         if (rd != 4'd0) ref_regs[rd] = wd;
      end else exp_q.push_back({ref_regs[rs1], ref_regs[rs2]});
      @(negedge clk);
      if (!hold) bif.req_valid = 1'b0;
      chk("issue_ports", 64'(rfvec), 64'({wr, rd, wd, rs1, rs2}));
      chk("ready_low_busy", 64'(bif.req_ready), 64'd0);
      av = 0;
      fell = 1'b0;
      err_fall = 1'b0;
      n = 0;
      while (!bif.req_ready && n < 400) begin
         if (bif.rf_available) av++;
         else if (av > 0 && !fell) begin
            fell = 1'b1;
            err_fall = bif.err;
         end
         @(negedge clk);
         n++;
      end
      chk("complete", 64'(bif.req_ready), 64'd1);
      chk("avail_cycles", 64'(av), 64'(exp_av));
      chk("err_at_release", 64'(err_fall), 64'(exp_err));
      chk("err", 64'(bif.err), 64'(exp_err));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time %0t exceeded, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) ref_regs[i] = '0;
      bif.req_valid = 1'b0;
      bif.req_write = 1'b0;
      bif.req_rd = '0;
      bif.req_rs1 = '0;
      bif.req_rs2 = '0;
      bif.req_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_avail", 64'(bif.rf_available), 64'd0);
      chk("rst_rsp_valid", 64'(bif.rsp_valid), 64'd0);
      chk("rst_err", 64'(bif.err), 64'd0);
      chk("rst_rsp", {bif.rsp_a, bif.rsp_b}, 64'd0);
      chk("rst_hold_regs", 64'(rfvec), 64'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1 chk("ready_after_reset", 64'(bif.req_ready), 64'd1);
      @(negedge clk);

      do_req(1'b1, 4'd5, 4'd0, 4'd0, 32'hDEADBEEF, 0, 1, 1'b0, -1);
      do_req(1'b0, 4'd0, 4'd5, 4'd0, 32'd0, 0, 1, 1'b0, -1);
      do_req(1'b1, 4'd3, 4'd0, 4'd0, 32'h12345678, 1, 2, 1'b0, -1);
      rdy_mode = 1;
      do_req(1'b0, 4'd0, 4'd0, 4'd3, 32'd0, 0, 1, 1'b0, -1);
      rdy_mode = 0;
      do_req(1'b1, 4'd7, 4'd0, 4'd0, 32'd1, 0, 1, 1'b1, -1);
      do_req(1'b0, 4'd0, 4'd7, 4'd5, 32'd0, 0, 1, 1'b0, 4);
      do_req(1'b0, 4'd0, 4'd3, 4'd5, 32'd0, 100, 1, 1'b0, -1);
      do_req(1'b1, 4'd9, 4'd0, 4'd0, 32'hA5A5_0009, 14, 1, 1'b0, -1);
      do_req(1'b1, 4'd10, 4'd0, 4'd0, 32'hBAD0_0010, 15, 1, 1'b0, -1);
      do_req(1'b0, 4'd0, 4'd9, 4'd10, 32'd0, 2, 3, 1'b0, -1);

      for (int k = 0; k < 40; k++) begin
         int r;
         int lat;
         r = $urandom_range(0, 9);
         lat = (r < 7) ? $urandom_range(0, 3) : (r == 7) ? 14 : (r == 8) ? 15 : 20;
         do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                4'($urandom_range(0, 7)), $urandom, lat, $urandom_range(1, 3),
                1'($urandom_range(0, 1)), -1);
      end
      bif.req_valid = 1'b0;

      // Asynchronous reset while the register file is still busy.
      bif.req_valid = 1'b1;
      bif.req_write = 1'b0;
      bif.req_rs1 = 4'd9;
      bif.req_rs2 = 4'd7;
      cfg_lat = 0;
      cfg_dur = 6;
      @(negedge clk);
      bif.req_valid = 1'b0;
      @(negedge clk);
      chk("in_wait", 64'(bif.rf_available && bif.rf_busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_avail", 64'(bif.rf_available), 64'd0);
      chk("async_rsp_valid", 64'(bif.rsp_valid), 64'd0);
      chk("async_err", 64'(bif.err), 64'd0);
      chk("async_idle", 64'(bif.req_ready), 64'd1);
      for (int i = 0; i < 16; i++) ref_regs[i] = '0;
      exp_err = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1 chk("ready_after_rerst", 64'(bif.req_ready), 64'd1);
      @(negedge clk);
      chk("no_pending", 64'(exp_q.size()), 64'd0);

      do_req(1'b0, 4'd0, 4'd9, 4'd7, 32'd0, 0, 1, 1'b0, -1);
      do_req(1'b1, 4'd4, 4'd0, 4'd0, 32'h0F0F_4444, 3, 2, 1'b0, -1);
      do_req(1'b0, 4'd0, 4'd4, 4'd0, 32'd0, 0, 1, 1'b0, -1);
      repeat (3) @(negedge clk);
      chk("drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
